// File: rtl/counter_pkg.sv
// counter_pkg: shared types, constants and helpers for the modulo counter.
//   cnt_mode_t : boundary behaviour (wrap or saturate)
//   PRE_W      : prescaler counter width
//   clamp_mod  : limits a value to the legal range 0..modulo-1
package counter_pkg;

  localparam int PRE_W = 16;

  typedef enum logic {CNT_WRAP, CNT_SATURATE} cnt_mode_t;

  function automatic logic [31:0] clamp_mod(input logic [31:0] value,
                                            input logic [31:0] modulo);
    return (value < modulo) ? value : (modulo - 32'd1);
  endfunction

endpackage

// File: rtl/nbit_counter_mod_tick_prescaler.sv
// tick_prescaler: divides the enable stream so that one tick is produced
// for every PRESCALE enabled cycles.
//   clk      in  system clock, rising edge
//   reset    in  asynchronous, active-low reset
//   en       in  advances the prescaler
//   sync_clr in  synchronous restart of the prescale phase
//   tick     out combinational step strobe (en && last phase)
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;

  // With PRESCALE=1 the counter sits at 0 = PRE_LAST, so tick follows en.
  assign tick = en && (pre_cnt_q == PRE_LAST);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (sync_clr) begin
      pre_cnt_d = '0;
    end else if (tick) begin
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/nbit_counter_mod.sv
// nbit_counter_mod: modulo-MODULO up/down counter with enable prescaler,
// synchronous clear/load and wrap or saturate boundary handling.
//   clk      in  system clock, rising edge
//   reset    in  asynchronous, active-low reset
//   en       in  count enable (gates the prescaler)
//   up       in  1 = increment, 0 = decrement
//   clr      in  synchronous clear (count, prescaler, ovf)
//   load     in  synchronous load of load_val (clamped to MODULO-1)
//   load_val in  value to load
//   count    out current count, registered
//   co       out one-cycle carry/borrow pulse, registered
//   ovf      out sticky overflow flag, registered
module nbit_counter_mod
  import counter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MODULO   = 2 ** N,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] count,
  output logic         co,
  output logic         ovf
);

  if ((MODULO > 2 ** N) || (MODULO < 2) || (PRESCALE < 1) || (PRESCALE > 65535)) begin : g_bad_param
    $error("nbit_counter_mod: illegal MODULO/PRESCALE for N");
  end

  localparam cnt_mode_t    MODE  = (SATURATE != 0) ? CNT_SATURATE : CNT_WRAP;
  localparam logic [N-1:0] TOP_V = N'(MODULO - 1);

  logic [N-1:0] count_q, count_d;
  logic         co_q, co_d;
  logic         ovf_q, ovf_d;
  logic         tick;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .sync_clr (clr | load),
    .tick     (tick)
  );

  always_comb begin
    count_d = count_q;
    co_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = N'(clamp_mod(32'(load_val), 32'(MODULO)));
    end else if (tick) begin
      if (up) begin
        if (count_q == TOP_V) begin
          co_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = (MODE == CNT_WRAP) ? '0 : count_q;
        end else begin
          // Widened by one bit so the sum can never alias when MODULO = 2**N.
          count_d = N'({1'b0, count_q} + (N+1)'(1));
        end
      end else begin
        if (count_q == '0) begin
          co_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = (MODE == CNT_WRAP) ? TOP_V : count_q;
        end else begin
          count_d = N'({1'b0, count_q} - (N+1)'(1));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign co    = co_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_nbit_counter_mod.sv
module tb_nbit_counter_mod;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up, clr, load;
  logic [3:0] load_val;

  logic [3:0] cnt_w, cnt_s, cnt_p, cnt_d;
  logic       co_w, co_s, co_p, co_d;
  logic       ovf_w, ovf_s, ovf_p, ovf_d;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // MODULO=10 wrap, PRESCALE=1
  nbit_counter_mod #(.N(4), .MODULO(10), .PRESCALE(1), .SATURATE(0)) u_wrap10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_w), .co(co_w), .ovf(ovf_w));

  // MODULO=10 saturate
  nbit_counter_mod #(.N(4), .MODULO(10), .PRESCALE(1), .SATURATE(1)) u_sat10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_s), .co(co_s), .ovf(ovf_s));

  // MODULO=10 wrap, PRESCALE=3
  nbit_counter_mod #(.N(4), .MODULO(10), .PRESCALE(3), .SATURATE(0)) u_pre3 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_p), .co(co_p), .ovf(ovf_p));

  // defaults: N=4, MODULO=16
  nbit_counter_mod #(.N(4)) u_def (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_d), .co(co_d), .ovf(ovf_d));

  typedef struct {
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [3:0] lv;
    logic [3:0] e_cnt;
    logic       e_co;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (%b) expected %0d", name, act, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic u, input logic c, input logic l,
                       input logic [3:0] lv);
    en = e; up = u; clr = c; load = l; load_val = lv;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic e, input logic u, input logic c, input logic l,
                         input logic [3:0] lv, input logic [3:0] ec,
                         input logic eco, input logic eovf);
    vec_t v;
    v.en = e; v.up = u; v.clr = c; v.load = l; v.lv = lv;
    v.e_cnt = ec; v.e_co = eco; v.e_ovf = eovf;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Vectors for u_wrap10 (MODULO=10, wrap, PRESCALE=1)
    for (int i = 1; i <= 9; i++) add_vec(1, 1, 0, 0, 4'd0, 4'(i), 0, 0);
    add_vec(1, 1, 0, 0, 4'd0,  4'd0, 1, 1);   // 9 -> 0 wrap
    add_vec(1, 1, 0, 0, 4'd0,  4'd1, 0, 1);   // co gone, ovf sticky
    add_vec(1, 1, 1, 0, 4'd0,  4'd0, 0, 0);   // clr
    add_vec(1, 0, 0, 0, 4'd0,  4'd9, 1, 1);   // 0 -> 9 borrow
    add_vec(1, 0, 0, 0, 4'd0,  4'd8, 0, 1);
    add_vec(1, 0, 1, 1, 4'd7,  4'd0, 0, 0);   // clr beats load
    add_vec(1, 0, 0, 1, 4'd12, 4'd9, 0, 0);   // clamped load
    add_vec(1, 0, 0, 1, 4'd3,  4'd3, 0, 0);
    add_vec(0, 1, 0, 0, 4'd0,  4'd3, 0, 0);   // en low holds
    add_vec(1, 1, 0, 0, 4'd0,  4'd4, 0, 0);

    reset = 1'b0;
    drive(0, 1, 0, 0, 4'd0);
    edge_step();
    edge_step();
    chk("rst_cnt_w", cnt_w, 0);
    chk("rst_co_w",  co_w,  0);
    chk("rst_ovf_w", ovf_w, 0);
    chk("rst_cnt_d", cnt_d, 0);
    @(negedge clk);
    reset = 1'b1;
    edge_step();
    chk("idle_cnt_w", cnt_w, 0);

    // Table-driven run against u_wrap10
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].up, vecs[i].clr, vecs[i].load, vecs[i].lv);
      edge_step();
      chk($sformatf("vec%0d_cnt", i), cnt_w, vecs[i].e_cnt);
      chk($sformatf("vec%0d_co",  i), co_w,  vecs[i].e_co);
      chk($sformatf("vec%0d_ovf", i), ovf_w, vecs[i].e_ovf);
    end

    // Saturate: repeated borrow at 0, then repeated carry at 9
    drive(1, 1, 1, 0, 4'd0);
    edge_step();
    drive(1, 0, 0, 0, 4'd0);
    edge_step();
    chk("sat_dn1_cnt", cnt_s, 0);
    chk("sat_dn1_co",  co_s,  1);
    chk("sat_dn1_ovf", ovf_s, 1);
    edge_step();
    chk("sat_dn2_cnt", cnt_s, 0);
    chk("sat_dn2_co",  co_s,  1);
    drive(0, 0, 0, 0, 4'd0);
    edge_step();
    chk("sat_idle_co",  co_s,  0);
    chk("sat_idle_ovf", ovf_s, 1);
    drive(1, 1, 0, 1, 4'd9);
    edge_step();
    chk("sat_ld_cnt", cnt_s, 9);
    chk("sat_ld_co",  co_s,  0);
    chk("sat_ld_ovf", ovf_s, 1);
    drive(1, 1, 0, 0, 4'd0);
    edge_step();
    chk("sat_up_cnt", cnt_s, 9);
    chk("sat_up_co",  co_s,  1);

    // Asynchronous reset between edges while co=1, ovf=1
    #2;
    reset = 1'b0;
    #1;
    chk("arst_cnt_s", cnt_s, 0);
    chk("arst_co_s",  co_s,  0);
    chk("arst_ovf_s", ovf_s, 0);
    chk("arst_cnt_w", cnt_w, 0);
    edge_step();
    @(negedge clk);
    reset = 1'b1;
    edge_step();
    chk("post_rst_cnt_s", cnt_s, 1);
    chk("post_rst_cnt_w", cnt_w, 1);
    chk("post_rst_cnt_p", cnt_p, 0);
    chk("post_rst_co_s",  co_s,  0);

    // Prescale by 3
    drive(1, 1, 1, 0, 4'd0);
    edge_step();
    drive(1, 1, 0, 0, 4'd0);
    for (int i = 1; i <= 9; i++) begin
      edge_step();
      chk($sformatf("pre_e%0d_cnt", i), cnt_p, 32'(i / 3));
    end
    edge_step();
    chk("pre_mid_cnt", cnt_p, 3);
    drive(0, 1, 0, 0, 4'd0);
    edge_step();
    edge_step();
    chk("pre_hold_cnt", cnt_p, 3);
    drive(1, 1, 0, 0, 4'd0);
    edge_step();
    chk("pre_res1_cnt", cnt_p, 3);
    edge_step();
    chk("pre_res2_cnt", cnt_p, 4);
    drive(1, 1, 0, 1, 4'd5);
    edge_step();
    chk("pre_ld_cnt", cnt_p, 5);
    drive(1, 1, 0, 0, 4'd0);
    edge_step();
    edge_step();
    chk("pre_ld_wait_cnt", cnt_p, 5);
    edge_step();
    chk("pre_ld_step_cnt", cnt_p, 6);

    // Default MODULO=16 full wrap
    drive(1, 1, 1, 0, 4'd0);
    edge_step();
    drive(1, 1, 0, 0, 4'd0);
    for (int i = 1; i <= 16; i++) begin
      edge_step();
      chk($sformatf("def_e%0d_cnt", i), cnt_d, 32'(i % 16));
      chk($sformatf("def_e%0d_co", i), co_d, (i == 16) ? 32'd1 : 32'd0);
    end
    chk("def_ovf", ovf_d, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nbit_counter_mod.md
Name: nbit_counter_mod

Overview:
Parametrised successor to the basic N-bit free-running counter. Modulo-M up/down counter with an integrated clock-enable prescaler, synchronous clear and load, and a wrap or saturate mode. Reports terminal events through a one-cycle carry pulse and a sticky overflow flag. Used as the general timing/event counter in lab designs, for example as a display-refresh divider, BCD digit counter or timeout timer.

Parameters:
N, 4, counter width in bits
MODULO, 2**N, count range 0..MODULO-1; legal range is 2..2**N
PRESCALE, 1, number of enabled cycles per count step; legal range is 1..65535
SATURATE, 0, 0 = wrap at the boundary; 1 = hold at the boundary

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  count enable; gates the prescaler
up  in  1  direction: 1 = increment, 0 = decrement
clr  in  1  synchronous clear
load  in  1  synchronous parallel load
load_val  in  N  value to load
count  out  N  current count (registered)
co  out  1  carry/borrow pulse (registered), one cycle long
ovf  out  1  sticky overflow flag (registered)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. While reset=0: count=0, co=0, ovf=0, prescaler=0, with no clock edge required.
- Update priority on each rising edge: reset > clr > load > tick step > hold.
- clr=1:
  - count←0, prescaler←0, ovf←0, co←0.
- load=1 (and clr=0):
  - count←load_val if load_val<MODULO, else count←MODULO-1 (clamped).
  - prescaler←0, co←0, ovf unchanged.
- Prescaler:
  - Internal counter pre_cnt runs 0..PRESCALE-1 and advances only when en=1.
  - tick = en && (pre_cnt==PRESCALE-1). When PRESCALE=1, tick equals en.
  - pre_cnt wraps to 0 on tick. When en=0, pre_cnt holds.
- Tick step (no clr, no load):
  - up=1, count<MODULO-1: count←count+1.
  - up=1, count==MODULO-1: boundary event. count←0 (wrap) or holds MODULO-1 (saturate).
  - up=0, count>0: count←count-1.
  - up=0, count==0: boundary event. count←MODULO-1 (wrap) or holds 0 (saturate).
- Boundary event:
  - co=1 for exactly the one cycle following the edge on which the event occurred. co=0 otherwise.
  - ovf←1 on the same edge. ovf stays high until clr or reset.
  - In saturate mode, every tick taken at the boundary is an event, so co repeats once per tick.
- Latency: count changes on the same edge where tick is sampled high. co and ovf are registered alongside count.
- up may change on any cycle; the value sampled at the edge applies.
- Arithmetic: next-value computation uses N+1 bits internally. count never leaves 0..MODULO-1.
- Parameter checks: an elaboration-time assertion rejects MODULO>2**N, MODULO<2 and PRESCALE<1.
- Reset asserted mid-prescale or mid-count: everything returns to 0 immediately. Counting resumes on the first enabled edge after reset deasserts.

Decomposition:
- Package counter_pkg:
  - typedef enum {CNT_WRAP, CNT_SATURATE} cnt_mode_t.
  - Function clamp_mod(value, modulo).
  - Prescaler width constant PRE_W=16.
- Sub-module tick_prescaler:
  - Parameter PRESCALE.
  - Ports clk, reset, en, sync_clr, tick.
  - Instantiated once.
  - Its sync_clr is driven by clr|load.

Test Plan:
1. N=4, MODULO=10, wrap, PRESCALE=1. en=1, up=1 from 0 for 11 cycles -> count 0,1,...,9,0. co=1 only in the cycle count shows 0 after 9. ovf=1 from then on.
2. Same configuration, up=0 from count 0, one tick -> count=9, co pulses once, ovf=1. With SATURATE=1 and two ticks -> count stays 0, co high on both ticks.
3. PRESCALE=3, en=1 for 9 cycles -> count 0→3, incrementing every 3rd edge. Drop en for 2 cycles mid-prescale -> count and pre_cnt hold, then resume with the correct phase.
4. clr=1 and load=1 with load_val=7 on the same edge -> count=0, ovf cleared. Next, load=1 with load_val=12 (MODULO=10) -> count=9. Load during an en stream -> the prescaler restarts, and the next step comes PRESCALE edges later.
5. Drive reset=0 between clock edges while count=5, co=1, ovf=1 -> all outputs 0 before the next edge. Release reset -> counting restarts from 0 on the next enabled edge.
6. Default MODULO=16, N=4, up=1 -> count wraps 15→0 with a co pulse. No X on count at any point.
